// File: rtl/llsc_link_unit_if.sv
// Purpose: EX-stage llsc fields into the LL/SC link unit, and the SC gate,
//          SC outcome and reservation state coming back out.
// Signals (seen from the link unit, i.e. the slave modport):
//   i_valid, i_lladdr_wr, i_is_sc, i_is_sw, i_link_clear : EX qualifiers
//   i_wr_reg_val  : ALU effective address, zero-extended
//   o_sc_store_en : comb D-cache write permit for the current SC
//   o_sc_valid    : registered 1-cycle pulse, o_sc_result is fresh
//   o_sc_result   : registered SC outcome (1 success / 0 fail)
//   o_link_valid  : registered reservation-held flag
//   o_link_addr   : registered reserved address
interface llsc_link_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 26
);
  logic                  i_valid;
  logic                  i_lladdr_wr;
  logic                  i_is_sc;
  logic                  i_is_sw;
  logic [DATA_WIDTH-1:0] i_wr_reg_val;
  logic                  i_link_clear;
  logic                  o_sc_store_en;
  logic                  o_sc_valid;
  logic [DATA_WIDTH-1:0] o_sc_result;
  logic                  o_link_valid;
  logic [ADDR_WIDTH-1:0] o_link_addr;

  // EX-stage side: drives the llsc fields, observes the outcome
  modport master (
    output i_valid, i_lladdr_wr, i_is_sc, i_is_sw, i_wr_reg_val, i_link_clear,
    input  o_sc_store_en, o_sc_valid, o_sc_result, o_link_valid, o_link_addr
  );

  // Link unit side
  modport slave (
    input  i_valid, i_lladdr_wr, i_is_sc, i_is_sw, i_wr_reg_val, i_link_clear,
    output o_sc_store_en, o_sc_valid, o_sc_result, o_link_valid, o_link_addr
  );
endinterface

// File: rtl/llsc_link_unit.sv
// Purpose: LL/SC reservation tracker for the single-issue core. Holds the
//          linked word address, gates the SC store in the same cycle and
//          reports the SC success flag to MEM one cycle later.
// Ports:
//   clk    : core clock
//   rst    : synchronous reset, active-high
//   io_bus : llsc_link_unit_if.slave (EX llsc fields in, SC gate/result and
//            reservation state out)
module llsc_link_unit #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned LINK_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  llsc_link_unit_if.slave        io_bus
);

  localparam int unsigned CNT_W = (LINK_TIMEOUT > 1) ? $clog2(LINK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((LINK_TIMEOUT == 0) ? 0 : (LINK_TIMEOUT - 1));
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LINKED = 1'b1;

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_link_addr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sc_valid;
  logic [DATA_WIDTH-1:0] r_sc_result;

  logic [0:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_link_addr_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_sc_valid_nxt;
  logic [DATA_WIDTH-1:0] w_sc_result_nxt;

  logic                  w_linked;
  logic                  w_match;
  logic                  w_ll;
  logic                  w_sc;
  logic                  w_sw;
  logic                  w_success;
  logic                  w_expire;
  logic                  w_unused;

  // Word-granular compare: byte offset bits never distinguish a reservation
  assign w_match   = (io_bus.i_wr_reg_val[ADDR_WIDTH-1:2] == r_link_addr[ADDR_WIDTH-1:2]);
  assign w_linked  = (r_state == S_LINKED);
  assign w_ll      = io_bus.i_valid & io_bus.i_lladdr_wr;
  assign w_sc      = io_bus.i_valid & io_bus.i_is_sc;
  assign w_sw      = io_bus.i_valid & io_bus.i_is_sw;
  // Success judged on the reservation held at the start of the cycle;
  // a coinciding clear always wins
  assign w_success = w_sc & w_linked & w_match & ~io_bus.i_link_clear;
  assign w_expire  = (LINK_TIMEOUT != 0) && (r_cnt == CNT_LAST);

  // Upper address bits beyond the word-address space are intentionally ignored
  assign w_unused  = ^io_bus.i_wr_reg_val;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_link_addr <= '0;
      r_cnt       <= '0;
      r_sc_valid  <= 1'b0;
      r_sc_result <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_link_addr <= w_link_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sc_valid  <= w_sc_valid_nxt;
      r_sc_result <= w_sc_result_nxt;
    end
  end

  // Next-state: clear > LL > SC/matching SW > timeout
  always_comb begin
    w_state_nxt     = r_state;
    w_link_addr_nxt = r_link_addr;
    w_cnt_nxt       = r_cnt;
    w_sc_valid_nxt  = 1'b0;
    w_sc_result_nxt = r_sc_result;

    if (w_sc) begin
      w_sc_valid_nxt  = 1'b1;
      w_sc_result_nxt = DATA_WIDTH'(w_success);
    end

    // Saturating age counter while a reservation is held
    if (w_linked && (r_cnt != CNT_MAX)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    if (io_bus.i_link_clear) begin
      w_state_nxt = S_IDLE;
    end else if (w_ll) begin
      w_state_nxt     = S_LINKED;
      w_link_addr_nxt = io_bus.i_wr_reg_val[ADDR_WIDTH-1:0];
      w_cnt_nxt       = '0;
    end else if (w_linked && (w_sc || (w_sw && w_match))) begin
      w_state_nxt = S_IDLE;
    end else if (w_linked && w_expire) begin
      w_state_nxt = S_IDLE;
    end
  end

  // SC store permit is zero-latency; an SC during reset is dropped
  assign io_bus.o_sc_store_en = w_success & ~rst;
  assign io_bus.o_sc_valid    = r_sc_valid;
  assign io_bus.o_sc_result   = r_sc_result;
  assign io_bus.o_link_valid  = w_linked;
  assign io_bus.o_link_addr   = r_link_addr;

  // LL and SC are mutually exclusive encodings
  a_ll_sc_excl: assert property (@(posedge clk) disable iff (rst)
    !(io_bus.i_valid && io_bus.i_lladdr_wr && io_bus.i_is_sc));

endmodule

// File: tb/tb_llsc_link_unit.sv
// Purpose: directed self-checking bench for llsc_link_unit (LINK_TIMEOUT=8).
module tb_llsc_link_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  llsc_link_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(26)) u_if ();

  llsc_link_unit #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (26),
    .LINK_TIMEOUT(8)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic ll, input logic sc, input logic sw,
                     input logic [31:0] addr, input logic clr);
    u_if.i_valid      = v;
    u_if.i_lladdr_wr  = ll;
    u_if.i_is_sc      = sc;
    u_if.i_is_sw      = sw;
    u_if.i_wr_reg_val = addr;
    u_if.i_link_clear = clr;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ll(input logic [31:0] a);  drv(1'b1, 1'b1, 1'b0, 1'b0, a, 1'b0); endtask
  task automatic sc(input logic [31:0] a);  drv(1'b1, 1'b0, 1'b1, 1'b0, a, 1'b0); endtask
  task automatic sw(input logic [31:0] a);  drv(1'b1, 1'b0, 1'b0, 1'b1, a, 1'b0); endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_link_valid", 32'(u_if.o_link_valid), 32'd0);
    chk("rst_link_addr",  32'(u_if.o_link_addr),  32'd0);
    chk("rst_sc_valid",   32'(u_if.o_sc_valid),   32'd0);
    chk("rst_sc_result",  u_if.o_sc_result,       32'd0);
    chk("rst_store_en",   32'(u_if.o_sc_store_en), 32'd0);

    // LL 0x100, idle, SC 0x100 -> success
    ll(32'h100); tick();
    chk("t1_link_valid", 32'(u_if.o_link_valid), 32'd1);
    chk("t1_link_addr",  32'(u_if.o_link_addr),  32'h100);
    idle(); tick();
    sc(32'h100);
    chk("t1_store_en", 32'(u_if.o_sc_store_en), 32'd1);
    tick();
    chk("t1_sc_valid",   32'(u_if.o_sc_valid),   32'd1);
    chk("t1_sc_result",  u_if.o_sc_result,       32'd1);
    chk("t1_link_drop",  32'(u_if.o_link_valid), 32'd0);
    idle(); tick();
    chk("t1_sc_pulse",   32'(u_if.o_sc_valid),   32'd0);
    chk("t1_result_hold", u_if.o_sc_result,      32'd1);

    // LL 0x100, SW 0x102 same word kills link, SC fails
    ll(32'h100); tick();
    sw(32'h102); tick();
    chk("t2_link_killed", 32'(u_if.o_link_valid), 32'd0);
    sc(32'h100);
    chk("t2_store_en", 32'(u_if.o_sc_store_en), 32'd0);
    tick();
    chk("t2_sc_valid",  32'(u_if.o_sc_valid), 32'd1);
    chk("t2_sc_result", u_if.o_sc_result,     32'd0);

    // LL 0x100, SW 0x200 other word, SC succeeds
    ll(32'h100); tick();
    sw(32'h200); tick();
    chk("t3_link_kept", 32'(u_if.o_link_valid), 32'd1);
    sc(32'h100);
    chk("t3_store_en", 32'(u_if.o_sc_store_en), 32'd1);
    tick();
    chk("t3_sc_result", u_if.o_sc_result, 32'd1);

    // Timeout: 8 idle cycles expire the link
    ll(32'h100); tick();
    idle();
    for (int i = 0; i < 7; i++) tick();
    chk("t4_alive_7", 32'(u_if.o_link_valid), 32'd1);
    tick();
    chk("t4_expired_8", 32'(u_if.o_link_valid), 32'd0);
    sc(32'h100);
    chk("t4_store_en", 32'(u_if.o_sc_store_en), 32'd0);
    tick();
    chk("t4_sc_result", u_if.o_sc_result, 32'd0);

    // 7 idle cycles: SC lands in the expiry cycle and still succeeds
    ll(32'h100); tick();
    idle();
    for (int i = 0; i < 7; i++) tick();
    sc(32'h100);
    chk("t5_store_en", 32'(u_if.o_sc_store_en), 32'd1);
    tick();
    chk("t5_sc_result", u_if.o_sc_result,      32'd1);
    chk("t5_link_drop", 32'(u_if.o_link_valid), 32'd0);

    // LL with clear in the same cycle leaves IDLE
    drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 1'b1); tick();
    chk("t6_ll_clr", 32'(u_if.o_link_valid), 32'd0);

    // SC with coinciding clear fails
    ll(32'h100); tick();
    drv(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1);
    chk("t6_sc_clr_store", 32'(u_if.o_sc_store_en), 32'd0);
    tick();
    chk("t6_sc_clr_valid",  32'(u_if.o_sc_valid),   32'd1);
    chk("t6_sc_clr_result", u_if.o_sc_result,       32'd0);
    chk("t6_sc_clr_link",   32'(u_if.o_link_valid), 32'd0);

    // SC without i_valid is ignored; link and outputs hold
    ll(32'h140); tick();
    drv(1'b0, 1'b0, 1'b1, 1'b0, 32'h140, 1'b0);
    chk("t7_novalid_store", 32'(u_if.o_sc_store_en), 32'd0);
    tick();
    chk("t7_novalid_scv",  32'(u_if.o_sc_valid),   32'd0);
    chk("t7_novalid_link", 32'(u_if.o_link_valid), 32'd1);

    // Re-link moves the reservation; upper address bits are dropped
    ll(32'hFC00_0200); tick();
    chk("t8_relink_addr", 32'(u_if.o_link_addr), 32'h200);
    sc(32'h140);
    chk("t8_old_addr_store", 32'(u_if.o_sc_store_en), 32'd0);
    tick();
    chk("t8_old_addr_result", u_if.o_sc_result, 32'd0);
    ll(32'h200); tick();
    sc(32'h0400_0203);
    chk("t8_hi_bits_store", 32'(u_if.o_sc_store_en), 32'd1);
    tick();
    chk("t8_hi_bits_result", u_if.o_sc_result, 32'd1);

    // Reset while LINKED with an SC in the reset cycle
    ll(32'h108); tick();
    sc(32'h108);
    rst = 1'b1;
    #1;
    chk("t9_rst_store", 32'(u_if.o_sc_store_en), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    chk("t9_link_valid", 32'(u_if.o_link_valid), 32'd0);
    chk("t9_link_addr",  32'(u_if.o_link_addr),  32'd0);
    chk("t9_sc_valid",   32'(u_if.o_sc_valid),   32'd0);
    chk("t9_sc_result",  u_if.o_sc_result,       32'd0);

    // SC with no prior LL fails
    sc(32'h0);
    chk("t10_nolink_store", 32'(u_if.o_sc_store_en), 32'd0);
    tick();
    chk("t10_nolink_valid",  32'(u_if.o_sc_valid), 32'd1);
    chk("t10_nolink_result", u_if.o_sc_result,     32'd0);
    idle(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
